// File: rtl/spi_pkg.sv
// Shared types for the SPI master: frame width, frame type and FSM states.
// CS_SETUP/CS_HOLD are only reachable when SPI_MASTER_CS_EN is defined.
package spi_pkg;

  localparam int FRAME_BITS = 32;

  typedef logic [FRAME_BITS-1:0] frame_t;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_clkgen.sv
// SCK divider: while en is high, sck toggles every CLK_DIV clk cycles,
// starting low. rise/fall are one-cycle strobes on the toggling cycle.
// Ports: clk, reset (async, high), en in; sck, rise, fall out.
module spi_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          tc;

  assign tc   = en & (cnt == LAST);
  assign rise = tc & ~sck;
  assign fall = tc & sck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (tc) begin
      cnt <= '0;
      sck <= ~sck;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master, 32-bit frames MSB first, valid/ready request side.
// Ports: clk, reset (async, high), tx_valid/tx_ready/tx_data in,
// rx_valid/rx_data out, busy, sck, sdo out, sdi in.
// Build option SPI_MASTER_CS_EN adds cs_n with setup/hold phases.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tx_valid,
  output logic   tx_ready,
  input  frame_t tx_data,
  output logic   rx_valid,
  output frame_t rx_data,
  output logic   busy,
  output logic   sck,
  output logic   sdo,
  input  logic   sdi
`ifdef SPI_MASTER_CS_EN
  ,
  output logic   cs_n
`endif
);

  spi_state_t state, nxt;
  frame_t     tx_sh, rx_sh;
  logic [4:0] bit_cnt;
  logic       armed;
  logic       en, rise, fall, last, accept;

  assign en     = (state == SHIFT);
  assign last   = fall & (bit_cnt == 5'd31);
  assign accept = tx_valid & tx_ready;

  spi_clkgen #(
    .CLK_DIV(CLK_DIV)
  ) u_clkgen (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .sck  (sck),
    .rise (rise),
    .fall (fall)
  );

`ifdef SPI_MASTER_CS_EN
  localparam int CW = $clog2(CLK_DIV + 1);

  logic [CW-1:0] gcnt;
  logic          gdone;
  logic          gate;

  assign gate  = (state == CS_SETUP) |
                 (state == CS_HOLD);
  assign gdone = gate &
                 (gcnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt <= '0;
    end else if (!gate || gdone) begin
      gcnt <= '0;
    end else begin
      gcnt <= gcnt + CW'(1);
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef SPI_MASTER_CS_EN
          nxt = CS_SETUP;
`else
          nxt = SHIFT;
`endif
        end
      end
`ifdef SPI_MASTER_CS_EN
      CS_SETUP: if (gdone) nxt = SHIFT;
      SHIFT:    if (last)  nxt = CS_HOLD;
      CS_HOLD:  if (gdone) nxt = DONE;
`else
      SHIFT:    if (last)  nxt = DONE;
`endif
      DONE:     nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // tx_ready waits one edge after reset release via armed.
  always_comb begin
    tx_ready = armed & (state == IDLE);
    busy     = (state != IDLE);
    rx_valid = (state == DONE);
    sdo      = busy & tx_sh[FRAME_BITS-1];
`ifdef SPI_MASTER_CS_EN
    cs_n     = ~((state == CS_SETUP) |
                 (state == SHIFT)    |
                 (state == CS_HOLD));
`endif
  end

  // The last fall leaves bit 0 on sdo and publishes the rx word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed   <= 1'b0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        tx_sh   <= tx_data;
        rx_sh   <= '0;
        bit_cnt <= '0;
      end
      if (en && rise) begin
        rx_sh <= {rx_sh[FRAME_BITS-2:0], sdi};
      end
      if (en && fall) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (last) begin
          rx_data <= rx_sh;
        end else begin
          tx_sh <= {tx_sh[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (CLK_DIV=4 and CLK_DIV=1) driven
// against a mode-0 slave model and frame-level timing expectations.
module tb_spi_master;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        tv[2];
  logic [31:0] td[2];
  logic        tr[2], rv[2], bz[2];
  logic        sck[2], sdo[2], sdi[2];
  logic [31:0] rd[2];
`ifdef SPI_MASTER_CS_EN
  logic        cs[2];
  localparam int CSX = 1;
`else
  localparam int CSX = 0;
`endif

  int total = 0;
  int bad = 0;

  int cyc = 0;
  int acc_cyc[2], acc_n[2], rise_n[2], fall_n[2];
  int first_rise[2], last_rise[2], last_fall[2];
  int per_err[2], busy_n[2], rb_viol[2];
  int rxv_n[2], rxv_cyc[2], csl_n[2];
  logic [31:0] slv_cap[2], slv_out[2], slv_word[2];
  bit   loop[2];
  logic psck[2];

  spi_master #(.CLK_DIV(4)) u4 (
    .clk(clk), .reset(reset),
    .tx_valid(tv[0]), .tx_ready(tr[0]), .tx_data(td[0]),
    .rx_valid(rv[0]), .rx_data(rd[0]), .busy(bz[0]),
    .sck(sck[0]), .sdo(sdo[0]), .sdi(sdi[0])
`ifdef SPI_MASTER_CS_EN
    , .cs_n(cs[0])
`endif
  );

  spi_master #(.CLK_DIV(1)) u1 (
    .clk(clk), .reset(reset),
    .tx_valid(tv[1]), .tx_ready(tr[1]), .tx_data(td[1]),
    .rx_valid(rv[1]), .rx_data(rd[1]), .busy(bz[1]),
    .sck(sck[1]), .sdo(sdo[1]), .sdi(sdi[1])
`ifdef SPI_MASTER_CS_EN
    , .cs_n(cs[1])
`endif
  );

  assign sdi[0] = loop[0] ? sdo[0] : slv_out[0][31];
  assign sdi[1] = loop[1] ? sdo[1] : slv_out[1][31];

  function automatic int dv(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Frame timing measured from the acceptance cycle.
  function automatic int lat(int k);
    return 64 * dv(k) + 1 + 2 * CSX * dv(k);
  endfunction

  function automatic int lead(int k);
    return dv(k) + 1 + CSX * dv(k);
  endfunction

  // Slave + observer, sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (tv[k] && tr[k]) begin
        acc_cyc[k] = cyc;
        acc_n[k]++;
        rise_n[k] = 0;
        fall_n[k] = 0;
        per_err[k] = 0;
        busy_n[k] = 0;
        csl_n[k] = 0;
        slv_cap[k] = 0;
        slv_out[k] = slv_word[k];
      end
      if (sck[k] && !psck[k]) begin
        if (rise_n[k] > 0 && cyc - last_rise[k] != 2 * dv(k))
          per_err[k]++;
        if (rise_n[k] == 0) first_rise[k] = cyc;
        last_rise[k] = cyc;
        rise_n[k]++;
        slv_cap[k] = {slv_cap[k][30:0], sdo[k]};
      end
      if (!sck[k] && psck[k]) begin
        fall_n[k]++;
        last_fall[k] = cyc;
        slv_out[k] = slv_out[k] << 1;
      end
      if (bz[k]) busy_n[k]++;
      if (bz[k] && tr[k]) rb_viol[k]++;
`ifdef SPI_MASTER_CS_EN
      if (!cs[k]) csl_n[k]++;
`endif
      if (rv[k]) begin
        rxv_n[k]++;
        rxv_cyc[k] = cyc;
      end
      psck[k] = sck[k];
    end
  end

  task automatic run_frame(input int k, input logic [31:0] d,
                           input logic [31:0] sw, input bit lp,
                           input bit chg, output bit to);
    int w;
    to = 0;
    slv_word[k] = sw;
    loop[k] = lp;
    @(posedge clk); #1;
    td[k] = d;
    tv[k] = 1'b1;
    w = 0;
    while (!tr[k] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!tr[k]) begin
      to = 1;
      tv[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!chg) tv[k] = 1'b0;
    w = 0;
    while (!rv[k] && w < 80 * dv(k) + 50) begin
      if (chg) td[k] = $urandom;
      @(posedge clk); #1;
      w++;
    end
    tv[k] = 1'b0;
    if (!rv[k]) to = 1;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      total++; if (tr[k] !== 1'b0) begin bad++; $display("FAIL rst_ready[%0d] got=%b exp=0", k, tr[k]); end
      total++; if (bz[k] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d] got=%b exp=0", k, bz[k]); end
      total++; if (sck[k] !== 1'b0) begin bad++; $display("FAIL rst_sck[%0d] got=%b exp=0", k, sck[k]); end
      total++; if (sdo[k] !== 1'b0) begin bad++; $display("FAIL rst_sdo[%0d] got=%b exp=0", k, sdo[k]); end
      total++; if (rv[k] !== 1'b0) begin bad++; $display("FAIL rst_rxv[%0d] got=%b exp=0", k, rv[k]); end
      total++; if (rd[k] !== 32'h0) begin bad++; $display("FAIL rst_rxd[%0d] got=%h exp=0", k, rd[k]); end
`ifdef SPI_MASTER_CS_EN
      total++; if (cs[k] !== 1'b1) begin bad++; $display("FAIL rst_csn[%0d] got=%b exp=1", k, cs[k]); end
`endif
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (tr[k] !== 1'b0) begin bad++; $display("FAIL rel_ready0[%0d] got=%b exp=0", k, tr[k]); end
    end
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      total++; if (tr[k] !== 1'b1) begin bad++; $display("FAIL rel_ready1[%0d] got=%b exp=1", k, tr[k]); end
    end
  endtask

  task automatic test_loopback();
    bit to;
    logic [31:0] d = 32'hA5C3_0F81;
    run_frame(0, d, 32'h0, 1, 0, to);
    total++; if (to) begin bad++; $display("FAIL lb_timeout got=1 exp=0"); end
    total++; if (rd[0] !== d) begin bad++; $display("FAIL lb_rxdata got=%h exp=%h", rd[0], d); end
    total++; if (rxv_cyc[0] - acc_cyc[0] != lat(0)) begin bad++; $display("FAIL lb_latency got=%0d exp=%0d", rxv_cyc[0] - acc_cyc[0], lat(0)); end
    total++; if (rise_n[0] != 32) begin bad++; $display("FAIL lb_rises got=%0d exp=32", rise_n[0]); end
    total++; if (fall_n[0] != 32) begin bad++; $display("FAIL lb_falls got=%0d exp=32", fall_n[0]); end
    total++; if (per_err[0] != 0) begin bad++; $display("FAIL lb_period got=%0d exp=0", per_err[0]); end
    total++; if (first_rise[0] - acc_cyc[0] != lead(0)) begin bad++; $display("FAIL lb_first_rise got=%0d exp=%0d", first_rise[0] - acc_cyc[0], lead(0)); end
    total++; if (last_fall[0] - acc_cyc[0] != 64 * 4 + 1 + CSX * 4) begin bad++; $display("FAIL lb_last_fall got=%0d exp=%0d", last_fall[0] - acc_cyc[0], 64 * 4 + 1 + CSX * 4); end
    total++; if (busy_n[0] != lat(0)) begin bad++; $display("FAIL lb_busy got=%0d exp=%0d", busy_n[0], lat(0)); end
    total++; if (slv_cap[0] !== d) begin bad++; $display("FAIL lb_slave got=%h exp=%h", slv_cap[0], d); end
`ifdef SPI_MASTER_CS_EN
    total++; if (csl_n[0] != 66 * 4) begin bad++; $display("FAIL lb_csn_low got=%0d exp=%0d", csl_n[0], 66 * 4); end
`endif
  endtask

  task automatic test_slave();
    bit to;
    run_frame(0, 32'h0000_03FF, 32'hDEAD_BEEF, 0, 0, to);
    total++; if (to) begin bad++; $display("FAIL slv_timeout got=1 exp=0"); end
    total++; if (slv_cap[0] !== 32'h0000_03FF) begin bad++; $display("FAIL slv_capture got=%h exp=000003ff", slv_cap[0]); end
    total++; if (rd[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL slv_rxdata got=%h exp=deadbeef", rd[0]); end
  endtask

  task automatic test_random();
    bit to;
    int k;
    logic [31:0] d, sw;
    for (int i = 0; i < 6; i++) begin
      k = i % 2;
      d = $urandom;
      sw = $urandom;
      run_frame(k, d, sw, 0, 0, to);
      total++; if (to) begin bad++; $display("FAIL rnd_timeout[%0d] got=1 exp=0", i); end
      total++; if (rd[k] !== sw) begin bad++; $display("FAIL rnd_rxdata[%0d] got=%h exp=%h", i, rd[k], sw); end
      total++; if (slv_cap[k] !== d) begin bad++; $display("FAIL rnd_slave[%0d] got=%h exp=%h", i, slv_cap[k], d); end
      total++; if (rxv_cyc[k] - acc_cyc[k] != lat(k)) begin bad++; $display("FAIL rnd_latency[%0d] got=%0d exp=%0d", i, rxv_cyc[k] - acc_cyc[k], lat(k)); end
    end
  endtask

  task automatic test_back_to_back();
    int w, a0, n0, r1;
    logic [31:0] sw = $urandom;
    slv_word[1] = sw;
    loop[1] = 0;
    a0 = acc_n[1];
    n0 = rxv_n[1];
    @(posedge clk); #1;
    td[1] = 32'hFFFF_0000;
    tv[1] = 1'b1;
    w = 0;
    while (rxv_n[1] == n0 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    r1 = rxv_cyc[1];
    total++; if (rd[1] !== sw) begin bad++; $display("FAIL b2b_rx1 got=%h exp=%h", rd[1], sw); end
    w = 0;
    while (acc_n[1] < a0 + 2 && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tv[1] = 1'b0;
    total++; if (acc_n[1] != a0 + 2) begin bad++; $display("FAIL b2b_accepts got=%0d exp=%0d", acc_n[1] - a0, 2); end
    total++; if (acc_cyc[1] - r1 != 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", acc_cyc[1] - r1); end
    w = 0;
    while (rxv_n[1] < n0 + 2 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    total++; if (rxv_n[1] != n0 + 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", rxv_n[1] - n0); end
    total++; if (rd[1] !== sw) begin bad++; $display("FAIL b2b_rx2 got=%h exp=%h", rd[1], sw); end
    total++; if (slv_cap[1] !== 32'hFFFF_0000) begin bad++; $display("FAIL b2b_slave got=%h exp=ffff0000", slv_cap[1]); end
    total++; if (per_err[1] != 0) begin bad++; $display("FAIL b2b_period got=%0d exp=0", per_err[1]); end
    total++; if (rise_n[1] != 32) begin bad++; $display("FAIL b2b_rises got=%0d exp=32", rise_n[1]); end
  endtask

  task automatic test_hold_change();
    bit to;
    int a0;
    logic [31:0] d = $urandom;
    logic [31:0] sw = $urandom;
    rb_viol[0] = 0;
    a0 = acc_n[0];
    run_frame(0, d, sw, 0, 1, to);
    total++; if (to) begin bad++; $display("FAIL hold_timeout got=1 exp=0"); end
    total++; if (slv_cap[0] !== d) begin bad++; $display("FAIL hold_slave got=%h exp=%h", slv_cap[0], d); end
    total++; if (rd[0] !== sw) begin bad++; $display("FAIL hold_rxdata got=%h exp=%h", rd[0], sw); end
    total++; if (rb_viol[0] != 0) begin bad++; $display("FAIL hold_ready_busy got=%0d exp=0", rb_viol[0]); end
    total++; if (acc_n[0] != a0 + 1) begin bad++; $display("FAIL hold_accepts got=%0d exp=1", acc_n[0] - a0); end
  endtask

  task automatic test_reset_abort();
    bit to;
    int w, n0;
    slv_word[0] = 32'h0;
    loop[0] = 1;
    @(posedge clk); #1;
    td[0] = 32'hFFFF_FFFF;
    tv[0] = 1'b1;
    w = 0;
    while (!tr[0] && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    @(posedge clk); #1;
    tv[0] = 1'b0;
    w = 0;
    while (rise_n[0] < 10 && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    total++; if (rise_n[0] < 10) begin bad++; $display("FAIL abort_wait got=%0d exp=10", rise_n[0]); end
    n0 = rxv_n[0];
    reset = 1'b1;
    #1;
    total++; if (sck[0] !== 1'b0) begin bad++; $display("FAIL abort_sck got=%b exp=0", sck[0]); end
    total++; if (sdo[0] !== 1'b0) begin bad++; $display("FAIL abort_sdo got=%b exp=0", sdo[0]); end
    total++; if (bz[0] !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bz[0]); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    total++; if (rxv_n[0] != n0) begin bad++; $display("FAIL abort_rxvalid got=%0d exp=0", rxv_n[0] - n0); end
    total++; if (rd[0] !== 32'h0) begin bad++; $display("FAIL abort_rxdata got=%h exp=0", rd[0]); end
    run_frame(0, 32'h1234_5678, 32'h0, 1, 0, to);
    total++; if (to) begin bad++; $display("FAIL abort_next_timeout got=1 exp=0"); end
    total++; if (rd[0] !== 32'h1234_5678) begin bad++; $display("FAIL abort_next_rx got=%h exp=12345678", rd[0]); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      tv[k] = 1'b0;
      td[k] = 32'h0;
      acc_cyc[k] = 0; acc_n[k] = 0;
      rise_n[k] = 0; fall_n[k] = 0;
      first_rise[k] = 0; last_rise[k] = 0;
      last_fall[k] = 0; per_err[k] = 0;
      busy_n[k] = 0; rb_viol[k] = 0;
      rxv_n[k] = 0; rxv_cyc[k] = 0;
      csl_n[k] = 0;
      slv_cap[k] = 0; slv_out[k] = 0;
      slv_word[k] = 0; loop[k] = 0;
      psck[k] = 1'b0;
    end
    test_reset();
    test_loopback();
    test_slave();
    test_random();
    test_back_to_back();
    test_hold_change();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
